// File: rtl/mux4_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: arbitrates four requests into
// registered S1/S0 select lines plus a one-hot grant, with capped grants and a turnaround gap.
module mux4_sel_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic       S0,
    output logic       S1,
    output logic [3:0] gnt,
    output logic       gnt_valid
);

    // req/gnt handshake: req[i] is level-sensitive and sampled on every rising edge.
    // A grant appears one edge after a sampled request. It stays live while req[i]
    // and en remain high, up to HOLD_MAX edges. Dropping req[i] or en releases it on
    // the next edge. A request raised during a live grant or a gap is not queued;
    // it is simply seen at the next IDLE arbitration edge if it is still high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             gv_q, gv_d;

    logic [1:0]       pick_idx;
    logic             release_now;

    // Scan from last+4 down to last+1 so the nearest set bit after last wins.
    always_comb begin
        pick_idx = last_q + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) begin
                pick_idx = last_q + 2'(k);
            end
        end
    end

    assign release_now = !req[sel_q] || !en || (cnt_q == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            gv_q    <= gv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        gv_d    = gv_q;
        case (state_q)
            IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    gv_d    = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                    gv_d    = 1'b0;
                    last_d  = sel_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                // Select lines keep the old index so the mux output never glitches.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                gv_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign S0        = sel_q[0];
    assign S1        = sel_q[1];
    assign gnt       = gnt_q;
    assign gnt_valid = gv_q;

    // Simulation-time guards for configuration and output invariants.
    always_ff @(posedge clk) begin
        assert (HOLD_MAX >= 1 && HOLD_MAX <= (2 ** CNT_W) - 1)
            else $error("mux4_sel_arbiter: HOLD_MAX=%0d out of range for CNT_W=%0d", HOLD_MAX, CNT_W);
        if (rst_n) begin
            assert ($onehot0(gnt_q))
                else $error("mux4_sel_arbiter: gnt not one-hot");
            assert (gv_q == (|gnt_q))
                else $error("mux4_sel_arbiter: gnt_valid disagrees with gnt");
            assert (cnt_q <= HOLD_LIM)
                else $error("mux4_sel_arbiter: hold count above limit");
        end
    end

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Self-checking bench for mux4_sel_arbiter: a HOLD_MAX=4 instance and a HOLD_MAX=1
// instance, with expected {gnt_valid,S1,S0,gnt} words queued as stimulus is driven.
module tb_mux4_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       S0, S1, gnt_valid;
    logic [3:0] gnt;
    logic       en1 = 1'b0;
    logic [3:0] req1 = 4'b0000;
    logic       s0_1, s1_1, gnt_valid1;
    logic [3:0] gnt1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    logic [6:0] obs, obs1;
    assign obs  = {gnt_valid, S1, S0, gnt};
    assign obs1 = {gnt_valid1, s1_1, s0_1, gnt1};

    always #5 clk = ~clk;

    mux4_sel_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .S0(S0), .S1(S1), .gnt(gnt), .gnt_valid(gnt_valid)
    );

    mux4_sel_arbiter #(.HOLD_MAX(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .req(req1),
        .S0(s0_1), .S1(s1_1), .gnt(gnt1), .gnt_valid(gnt_valid1)
    );

    // Expected output word: live grant of channel idx, or idle with S1/S0 parked at idx.
    function automatic logic [6:0] enc(bit gv, int idx);
        logic [1:0] i2;
        i2 = 2'(idx);
        return {gv, i2, gv ? (4'b0001 << i2) : 4'b0000};
    endfunction

    task automatic apply_reset();
        en = 1'b0; req = 4'b0000; en1 = 1'b0; req1 = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b0; req = 4'b1111; en1 = 1'b0; req1 = 4'b1111;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_main: got %b required %b", obs, 7'b0);
        end
        n_checks++;
        if (obs1 !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold1: got %b required %b", obs1, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_en_low_idle: got %b required %b", obs, 7'b0);
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] e;
        int step = 0;
        apply_reset();
        en = 1'b1; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) exp_q.push_back(enc(1'b1, g % 4));
            if (g < 4) repeat (2) exp_q.push_back(enc(1'b0, g % 4));
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            step++;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL round_robin step %0d: got %b required %b", step, obs, e);
            end
            n_checks++;
            if ((gnt_valid !== (|gnt)) || !$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL round_robin_onehot step %0d: got gnt=%b gnt_valid=%b", step, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_sole_requester();
        logic [6:0] e;
        int step = 0;
        apply_reset();
        en = 1'b1; req = 4'b0100;
        repeat (2) begin
            repeat (4) exp_q.push_back(enc(1'b1, 2));
            repeat (2) exp_q.push_back(enc(1'b0, 2));
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            step++;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL sole_requester step %0d: got %b required %b", step, obs, e);
            end
        end
    endtask

    task automatic test_release_early();
        logic [3:0] req_t [9];
        logic [6:0] exp_t [9];
        logic [6:0] e;
        req_t = '{4'b0010, 4'b1010, 4'b1000, 4'b1000, 4'b1000,
                  4'b1000, 4'b1000, 4'b1000, 4'b1000};
        exp_t = '{enc(1, 1), enc(1, 1), enc(0, 1), enc(0, 1), enc(1, 3),
                  enc(1, 3), enc(1, 3), enc(1, 3), enc(0, 3)};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            en = 1'b1;
            req = req_t[i];
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL release_early step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_enable();
        logic       en_t  [12];
        logic [6:0] exp_t [12];
        logic [6:0] e;
        en_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t = '{enc(0, 0), enc(0, 0), enc(0, 0), enc(0, 0), enc(1, 1), enc(1, 1),
                  enc(0, 1), enc(0, 1), enc(0, 1), enc(0, 1), enc(1, 3), enc(1, 3)};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            en = en_t[i];
            req = 4'b1010;
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL enable step %0d: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] e;
        int step = 0;
        apply_reset();
        en = 1'b1; req = 4'b1111;
        repeat (4) exp_q.push_back(enc(1, 0));
        repeat (2) exp_q.push_back(enc(0, 0));
        repeat (4) exp_q.push_back(enc(1, 1));
        repeat (2) exp_q.push_back(enc(0, 1));
        repeat (2) exp_q.push_back(enc(1, 2));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            step++;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_reset_pre step %0d: got %b required %b", step, obs, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b required %b", obs, 7'b0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_held: got %b required %b", obs, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) exp_q.push_back(enc(1, 0));
        step = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            step++;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_reset_post step %0d: got %b required %b", step, obs, e);
            end
        end
    endtask

    task automatic test_hold1();
        logic [6:0] e;
        int step = 0;
        apply_reset();
        en1 = 1'b1; req1 = 4'b0011;
        for (int g = 0; g < 4; g++) begin
            exp_q.push_back(enc(1, g % 2));
            if (g < 3) repeat (2) exp_q.push_back(enc(0, g % 2));
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            step++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL hold1 step %0d: got %b required %b", step, obs1, e);
            end
            n_checks++;
            if ((gnt_valid1 !== (|gnt1)) || !$onehot0(gnt1)) begin
                n_fail++;
                $display("FAIL hold1_onehot step %0d: got gnt=%b gnt_valid=%b", step, gnt1, gnt_valid1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_release_early();
        test_enable();
        test_async_reset();
        test_hold1();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
